time_encoder: RTL



---
 rtl/time_encoder_if.sv | 18 +
 rtl/time_encoder.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/time_encoder_if.sv
// ============================================================================
//  Module   : time_encoder_if
//  Purpose  : Valid/ready load port carrying the packed {minute, second} word
//             from the keypad encoder to the countdown counter.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface time_encoder_if;
  logic [11:0] counter_out;
  logic        out_valid;
  logic        out_ready;

  modport master (output counter_out, output out_valid, input out_ready);
  modport slave  (input counter_out, input out_valid, output out_ready);
endinterface

`default_nettype wire

// File: rtl/time_encoder.sv
// ============================================================================
//  Module   : time_encoder
//  Purpose  : Shift-in BCD keypad entry encoded to a packed {min, sec} timer
//             word, range checked, delivered over a valid/ready load port.
//  Option   : TIME_ENCODER_NORMALIZE_EN - fold seconds 60..99 into minutes.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module time_encoder #(
  parameter int MAX_MIN = 59,
  parameter int NDIG    = 4
) (
  input  wire logic                 clk,
  input  wire logic                 nrst,
  input  wire logic [3:0]           digit_in,
  input  wire logic                 digit_strobe,
  input  wire logic                 clear,
  input  wire logic                 commit,
  time_encoder_if.master            load,
  output logic                      err,
  output logic [NDIG*4-1:0]         entry_digits,
  output logic [2:0]                digit_count
);

  localparam int          BW        = NDIG * 4;
  localparam logic [2:0]  MAX_COUNT = 3'(NDIG);
  localparam logic [7:0]  MAX_MIN_W = 8'(MAX_MIN);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ENTRY   = 2'd1,
    CONVERT = 2'd2,
    HOLD    = 2'd3
  } state_t;

  state_t         state_q, state_d;
  logic [BW-1:0]  digits_q, digits_d;
  logic [2:0]     count_q, count_d;
  logic           err_q, err_d;
  logic           valid_q, valid_d;
  logic [11:0]    word_q, word_d;

  logic [6:0]     mins, secs;
  logic [7:0]     mins_adj;
  logic [6:0]     secs_adj;
  logic           range_bad;
  logic [11:0]    packed_time;

  // Decimal minutes/seconds from the four most recent digits
  always_comb begin
    mins = 7'(digits_q[BW-1 -: 4]) * 7'd10 + 7'(digits_q[BW-5 -: 4]);
    secs = 7'(digits_q[7:4]) * 7'd10 + 7'(digits_q[3:0]);
`ifdef TIME_ENCODER_NORMALIZE_EN
    if (secs > 7'd59) begin
      mins_adj = {1'b0, mins} + 8'd1;
      secs_adj = secs - 7'd60;
    end else begin
      mins_adj = {1'b0, mins};
      secs_adj = secs;
    end
    range_bad = (mins_adj > MAX_MIN_W);
`else
    mins_adj  = {1'b0, mins};
    secs_adj  = secs;
    range_bad = (secs > 7'd59) || (mins_adj > MAX_MIN_W);
`endif
    packed_time = {6'(mins_adj), 6'(secs_adj)};
  end

  always_comb begin
    state_d  = state_q;
    digits_d = digits_q;
    count_d  = count_q;
    err_d    = 1'b0;
    valid_d  = valid_q;
    word_d   = word_q;

    case (state_q)
      IDLE, ENTRY: begin
        if (clear) begin
          digits_d = '0;
          count_d  = '0;
          state_d  = IDLE;
        end else if (commit) begin
          state_d = CONVERT;
        end else if (digit_strobe) begin
          if (digit_in <= 4'd9) begin
            digits_d = {digits_q[BW-5:0], digit_in};
            count_d  = (count_q == MAX_COUNT) ? count_q : count_q + 3'd1;
            state_d  = ENTRY;
          end else begin
            err_d = 1'b1;
          end
        end
      end

      CONVERT: begin
        if (range_bad) begin
          err_d   = 1'b1;
          state_d = ENTRY;
        end else begin
          word_d  = packed_time;
          valid_d = 1'b1;
          state_d = HOLD;
        end
      end

      HOLD: begin
        // Keypad inputs, including clear, cannot abort a pending transfer
        if (valid_q && load.out_ready) begin
          valid_d  = 1'b0;
          digits_d = '0;
          count_d  = '0;
          state_d  = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q  <= IDLE;
      digits_q <= '0;
      count_q  <= '0;
      err_q    <= 1'b0;
      valid_q  <= 1'b0;
      word_q   <= '0;
    end else begin
      state_q  <= state_d;
      digits_q <= digits_d;
      count_q  <= count_d;
      err_q    <= err_d;
      valid_q  <= valid_d;
      word_q   <= word_d;
    end
  end

  assign load.counter_out = word_q;
  assign load.out_valid   = valid_q;
  assign err              = err_q;
  assign entry_digits     = digits_q;
  assign digit_count      = count_q;

endmodule

`default_nettype wire
